// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_seq_pkg
//  Description : Shared types for the SPI flash command sequencer: FSM state
//                encoding, the 9-bit byte-count type and the address byte
//                selector used by the TX byte mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

  // Byte counts reach 1 + 3 + 15 + 255 = 274, so 9 bits are needed.
  localparam int c_TOTAL_W = 9;

  typedef logic [c_TOTAL_W-1:0] total_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACTIVE = 3'd2,
    S_HOLD   = 3'd3,
    S_ABORT  = 3'd4
  } seq_state_t;

  // Address byte k (1-based) of an nbytes-wide address, MSB first.
  // The distance from the last address byte selects the 8-bit lane.
  function automatic logic [7:0] addr_byte(input logic [23:0] a,
                                           input logic [1:0]  nbytes,
                                           input logic [1:0]  k);
    logic [1:0] w_lane;
    w_lane = nbytes - k;
    case (w_lane)
      2'd0:    addr_byte = a[7:0];
      2'd1:    addr_byte = a[15:8];
      default: addr_byte = a[23:16];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_seq
//  Description : Sequences one SPI flash transaction (command, address,
//                dummy and data bytes) into an SPI engine's TX/RX FIFOs,
//                with host-side write/read handshakes, CS hold time and
//                abort with FIFO flush.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n          : clock, synchronous active-low reset
//    start, abort        : launch / cancel a transaction
//    cmd, addr,
//    addr_bytes, dummy,
//    len, dir            : transaction descriptor, latched on start
//    wdata/wvalid/wready : host write data stream (dir = 0)
//    rdata/rvalid/rready : host read data stream  (dir = 1)
//    busy, done, aborted : status
//    spi_*               : SPI engine FIFO and control interface
// ============================================================================
module spi_flash_seq
  import spi_seq_pkg::*;
#(
  parameter int CSH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cmd,
  input  logic [23:0] addr,
  input  logic [1:0]  addr_bytes,
  input  logic [3:0]  dummy,
  input  logic [7:0]  len,
  input  logic        dir,
  input  logic [7:0]  wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic [7:0]  rdata,
  output logic        rvalid,
  input  logic        rready,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        spi_wr,
  output logic [7:0]  spi_datai,
  input  logic        spi_tx_full,
  output logic        spi_rd,
  input  logic [7:0]  spi_datao,
  input  logic        spi_rx_empty,
  input  logic        spi_busy,
  output logic        spi_ss,
  output logic        spi_rx_en,
  output logic        spi_tx_flush,
  output logic        spi_rx_flush
);

  seq_state_t  r_state;
  logic [7:0]  r_cmd;
  logic [23:0] r_addr;
  logic [1:0]  r_abytes;
  logic        r_dir;
  total_t      r_hdr;       // 1 + addr_bytes + dummy: first data byte index
  total_t      r_total;
  total_t      r_tx_cnt;
  total_t      r_rx_cnt;
  logic [3:0]  r_hold_cnt;

  logic r_ss;
  logic r_rx_en;
  logic r_busy;
  logic r_done;
  logic r_aborted;
  logic r_tx_flush;
  logic r_rx_flush;

  logic       w_active;
  logic       w_tx_pend;
  logic       w_tx_wphase;
  logic       w_spi_wr;
  logic       w_rx_pend;
  logic       w_rx_rphase;
  logic       w_rx_discard;
  logic       w_spi_rd;
  logic       w_rvalid;
  logic [7:0] w_tx_byte;

  // An abort in the same cycle already suppresses all FIFO/host strobes.
  assign w_active     = (r_state == S_ACTIVE) && !abort;

  assign w_tx_pend    = r_tx_cnt < r_total;
  assign w_tx_wphase  = w_tx_pend && !r_dir && (r_tx_cnt >= r_hdr);
  assign w_spi_wr     = w_active && w_tx_pend && !spi_tx_full &&
                        (!w_tx_wphase || wvalid);

  assign w_rx_pend    = r_rx_cnt < r_total;
  assign w_rx_rphase  = w_active && w_rx_pend && r_dir && (r_rx_cnt >= r_hdr);
  // Header echoes, and everything during a write, are dropped internally.
  assign w_rx_discard = w_active && w_rx_pend && !(r_dir && (r_rx_cnt >= r_hdr));
  assign w_rvalid     = w_rx_rphase && !spi_rx_empty;
  assign w_spi_rd     = !spi_rx_empty && (w_rx_discard || (w_rx_rphase && rready));

  always_comb begin
    w_tx_byte = 8'h00;
    if (r_tx_cnt == '0) begin
      w_tx_byte = r_cmd;
    end else if (r_tx_cnt <= {7'd0, r_abytes}) begin
      w_tx_byte = addr_byte(r_addr, r_abytes, r_tx_cnt[1:0]);
    end else if (w_tx_wphase) begin
      w_tx_byte = wdata;
    end
  end

  assign spi_wr    = w_spi_wr;
  assign spi_datai = w_spi_wr ? w_tx_byte : 8'h00;
  assign wready    = w_spi_wr && w_tx_wphase;
  assign spi_rd    = w_spi_rd;
  assign rvalid    = w_rvalid;
  assign rdata     = w_rvalid ? spi_datao : 8'h00;

  assign spi_ss       = r_ss;
  assign spi_rx_en    = r_rx_en;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign spi_tx_flush = r_tx_flush;
  assign spi_rx_flush = r_rx_flush;

  // Status outputs are registered alongside the state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= 8'h00;
      r_addr     <= 24'h0;
      r_abytes   <= 2'd0;
      r_dir      <= 1'b0;
      r_hdr      <= '0;
      r_total    <= '0;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_hold_cnt <= 4'd0;
      r_ss       <= 1'b0;
      r_rx_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_tx_flush <= 1'b0;
      r_rx_flush <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_tx_flush <= 1'b0;
      r_rx_flush <= 1'b0;

      if (w_spi_wr) r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_spi_rd) r_rx_cnt <= r_rx_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          // start wins over a simultaneous abort here.
          if (start) begin
            r_cmd    <= cmd;
            r_addr   <= addr;
            r_abytes <= addr_bytes;
            r_dir    <= dir;
            r_hdr    <= 9'd1 + {7'd0, addr_bytes} + {5'd0, dummy};
            r_total  <= 9'd1 + {7'd0, addr_bytes} + {5'd0, dummy} + {1'b0, len};
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_ss     <= 1'b1;
            r_rx_en  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_state <= abort ? S_ABORT : S_ACTIVE;
        end

        S_ACTIVE: begin
          if (abort) begin
            r_state <= S_ABORT;
          end else if ((r_rx_cnt == r_total) && !spi_busy) begin
            r_hold_cnt <= 4'd0;
            r_state    <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (abort) begin
            r_state <= S_ABORT;
          end else if (r_hold_cnt == 4'(CSH - 1)) begin
            r_ss    <= 1'b0;
            r_rx_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end

        S_ABORT: begin
          // Let the byte on the wire finish before flushing the FIFOs.
          if (!spi_busy) begin
            r_tx_flush <= 1'b1;
            r_rx_flush <= 1'b1;
            r_aborted  <= 1'b1;
            r_ss       <= 1'b0;
            r_rx_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: begin
          r_ss    <= 1'b0;
          r_rx_en <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_seq.md
SPI_FLASH_SEQ -- requirements
Module: spi_flash_seq

Interface
REQ-001 The block SHALL have parameter CSH, default 2, giving the number of clk cycles CS stays asserted after the last byte completes (range 1..15).
REQ-002 Ports SHALL be, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  one-cycle pulse that launches a transaction; accepted only in IDLE.
- abort  in  1  pulse that cancels the transaction in progress.
- cmd  in  8  command byte.
- addr  in  24  address, sent MSB first.
- addr_bytes  in  2  number of address bytes, 0..3.
- dummy  in  4  number of dummy bytes, 0..15.
- len  in  8  number of data bytes, 0..255.
- dir  in  1  1 = read, 0 = write.
- wdata  in  8  write data byte.
- wvalid  in  1  wdata is valid.
- wready  out  1  wdata accepted this cycle.
- rdata  out  8  read data byte.
- rvalid  out  1  rdata is valid.
- rready  in  1  host accepts rdata.
- busy  out  1  sequencer is not IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.
- spi_wr  out  1  write to the SPI TX FIFO.
- spi_datai  out  8  TX FIFO write data.
- spi_tx_full  in  1  TX FIFO is full.
- spi_rd  out  1  pop from the SPI RX FIFO.
- spi_datao  in  8  RX FIFO head; first-word-fall-through, valid while !spi_rx_empty.
- spi_rx_empty  in  1  RX FIFO is empty.
- spi_busy  in  1  SPI engine is shifting a byte.
- spi_ss  out  1  chip-select request to the SPI block.
- spi_rx_en  out  1  RX capture enable.
- spi_tx_flush  out  1  TX FIFO flush.
- spi_rx_flush  out  1  RX FIFO flush.

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, ACTIVE, HOLD and ABORT.
REQ-004 In IDLE, start SHALL latch cmd, addr, addr_bytes, dummy, len and dir, compute TOTAL = 1+addr_bytes+dummy+len as a 9-bit value (max 274), clear tx_cnt and rx_cnt (9-bit), and move to SETUP.
REQ-005 SETUP SHALL last exactly one cycle with spi_ss=1 and spi_wr=0, then move to ACTIVE.
REQ-006 The TX byte at index i SHALL be:
- i=0: cmd.
- i=1..addr_bytes: addr bytes, MSB-first (addr_bytes=3 gives [23:16],[15:8],[7:0]; 2 gives [15:8],[7:0]; 1 gives [7:0]).
- next dummy bytes: 0x00.
- data phase: wdata if dir=0, otherwise 0x00.
REQ-007 In ACTIVE, spi_wr SHALL equal tx_cnt<TOTAL AND !spi_tx_full AND (not a write data byte OR wvalid), and tx_cnt SHALL increment on every spi_wr.
REQ-008 wready SHALL equal spi_wr during the write data phase and 0 otherwise; a low wvalid stalls TX without error.
REQ-009 Every transmitted byte yields one RX byte. The first 1+addr_bytes+dummy RX bytes SHALL be popped and discarded, as SHALL all RX bytes when dir=0.
REQ-010 Read data phase:
- rvalid = !spi_rx_empty.
- rdata = spi_datao.
- spi_rd = rvalid AND rready.
- A host stall SHALL NOT drop bytes; the RX FIFO backs up and the SPI block stalls.
REQ-011 rx_cnt SHALL increment on every spi_rd. When rx_cnt==TOTAL and !spi_busy, the FSM SHALL enter HOLD.
REQ-012 HOLD SHALL keep spi_ss=1 for CSH cycles, then pulse done for one cycle and return to IDLE with spi_ss=0.
REQ-013 spi_ss and spi_rx_en SHALL be 1 in SETUP, ACTIVE and HOLD, and 0 in IDLE.
REQ-014 Abort handling:
- abort in SETUP, ACTIVE or HOLD SHALL enter ABORT, with spi_wr, spi_rd and wready forced to 0.
- ABORT SHALL wait for !spi_busy, then assert spi_tx_flush and spi_rx_flush for one cycle, drop spi_ss, pulse aborted and return to IDLE.
- abort in IDLE SHALL be ignored.
REQ-015 start outside IDLE SHALL be ignored. Simultaneous start and abort in IDLE SHALL start the transaction.
REQ-016 len=0 SHALL perform a command/address-only transaction with no wready and no rvalid.

Reset
REQ-017 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE and the counters SHALL clear.
REQ-018 After reset, all outputs SHALL be 0: busy, done, aborted, spi_wr, spi_rd, spi_ss, spi_rx_en, both flushes, wready, rvalid, rdata, spi_datai.
REQ-019 Reset mid-transaction SHALL drop spi_ss the next cycle and SHALL NOT pulse done or aborted.

Structure
REQ-020 State encodings and the TOTAL width (9) SHALL live in the shared package spi_seq_pkg.
REQ-021 There SHALL be no sub-module: a single module containing the FSM, two counters and the TX byte mux.

Verification
REQ-022 The bench SHALL cover:
- Read cmd=0x03, addr=0x123456, addr_bytes=3, dummy=0, len=4, miso model returns 0xA0..0xA3 -> TX 03 12 34 56 00 00 00 00; rdata A0,A1,A2,A3; done once; spi_ss low CSH cycles after the last byte.
- Write cmd=0x02, addr_bytes=2, addr=0x00BEEF, len=2, wdata 0x11 then 0x22 with wvalid gaps -> TX 02 BE EF 11 22; exactly 2 wready; no rvalid.
- Fast read cmd=0x0B, addr_bytes=3, dummy=1, len=3, rready held low 20 cycles -> no byte loss; 3 rvalid handshakes; rx_cnt ends at 8.
- cmd=0x06, addr_bytes=0, len=0 -> single TX byte 0x06; done.
- abort during byte 3 of a 10-byte read -> both flushes pulse after spi_busy falls; aborted pulse; no done; next start succeeds.
- start while busy, and rst_n low mid-transfer -> start ignored; reset yields all outputs 0 and spi_ss low.
